// File: rtl/fp_div_pipe.sv
`default_nettype none
// ============================================================================
// fp_div_pipe : fully pipelined IEEE-754 divider (a / b), RNE, subnormals, flags
// Revision    : 1.0
// ============================================================================
module fp_div_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     flag_invalid,
    output logic                     flag_div_zero,
    output logic                     flag_overflow,
    output logic                     flag_underflow,
    output logic                     flag_inexact
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int M    = MAN_W + 1;
    localparam int LAT  = M + 4;
    localparam int NS   = LAT - 2;
    localparam int EW   = EXP_W + 3;
    localparam int LZ_W = $clog2(M + 1);

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [LZ_W-1:0] f_lzc(input logic [M-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (!found && !v[i]) n = n + LZ_W'(1);
            else                 found = 1'b1;
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- unpack
    logic [EXP_W-1:0]      w_ea_f, w_eb_f;
    logic [MAN_W-1:0]      w_ma_f, w_mb_f;
    logic                  w_a_zero, w_a_inf, w_a_nan, w_a_snan;
    logic                  w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic [M-1:0]          w_siga_raw, w_sigb_raw, w_siga, w_sigb;
    logic [LZ_W-1:0]       w_lza, w_lzb;
    logic [EW-1:0]         w_xa, w_xb;
    logic signed [EW-1:0]  w_e;
    logic                  w_sign;
    logic [1:0]            w_spec;
    logic                  w_finv, w_fdz;

    assign w_ea_f   = a[W-2 -: EXP_W];
    assign w_eb_f   = b[W-2 -: EXP_W];
    assign w_ma_f   = a[MAN_W-1:0];
    assign w_mb_f   = b[MAN_W-1:0];

    assign w_a_zero = (w_ea_f == '0) && (w_ma_f == '0);
    assign w_b_zero = (w_eb_f == '0) && (w_mb_f == '0);
    assign w_a_inf  = (w_ea_f == '1) && (w_ma_f == '0);
    assign w_b_inf  = (w_eb_f == '1) && (w_mb_f == '0);
    assign w_a_nan  = (w_ea_f == '1) && (w_ma_f != '0);
    assign w_b_nan  = (w_eb_f == '1) && (w_mb_f != '0);
    assign w_a_snan = w_a_nan && !w_ma_f[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_mb_f[MAN_W-1];

    // Subnormals are normalised here so the divider always sees MSB-set operands
    assign w_siga_raw = {|w_ea_f, w_ma_f};
    assign w_sigb_raw = {|w_eb_f, w_mb_f};
    assign w_lza      = f_lzc(w_siga_raw);
    assign w_lzb      = f_lzc(w_sigb_raw);
    assign w_siga     = w_siga_raw << w_lza;
    assign w_sigb     = w_sigb_raw << w_lzb;
    assign w_xa       = (w_ea_f == '0) ? (EW'(1) - EW'(w_lza)) : EW'(w_ea_f);
    assign w_xb       = (w_eb_f == '0) ? (EW'(1) - EW'(w_lzb)) : EW'(w_eb_f);
    assign w_e        = w_xa - w_xb + EW'(BIAS);
    assign w_sign     = a[W-1] ^ b[W-1];

    always_comb begin
        w_spec = SP_NONE;
        w_finv = 1'b0;
        w_fdz  = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec = SP_NAN;
            w_finv = w_a_snan || w_b_snan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
        end else if (w_a_inf || w_b_zero) begin
            w_spec = SP_INF;
            w_fdz  = w_b_zero && !w_a_inf && !w_a_zero;
        end else if (w_a_zero || w_b_inf) begin
            w_spec = SP_ZERO;
        end
    end

    // -------------------------------------------------------- pipeline state
    logic [NS:0]           r_vld;
    logic [NS:0]           r_sign;
    logic [NS:0]           r_finv;
    logic [NS:0]           r_fdz;
    logic [1:0]            r_spec [0:NS];
    logic signed [EW-1:0]  r_exp  [0:NS];
    logic [M-1:0]          r_sigb [0:NS-1];
    logic [M:0]            r_rem  [0:NS];
    logic [M+1:0]          r_q    [0:NS];

    // ------------------------------------------- restoring divider, 1 bit/stage
    logic [M:0]            w_d    [1:NS];
    logic [M:0]            w_rem  [1:NS];
    logic [M+1:0]          w_q    [1:NS];
    logic [NS:1]           w_qbit;

    always_comb begin
        for (int j = 1; j <= NS; j++) begin
            w_d[j]         = (j == 1) ? r_rem[0] : {r_rem[j-1][M-1:0], 1'b0};
            w_qbit[j]      = (w_d[j] >= {1'b0, r_sigb[j-1]});
            w_rem[j]       = w_qbit[j] ? (w_d[j] - {1'b0, r_sigb[j-1]}) : w_d[j];
            w_q[j]         = r_q[j-1];
            w_q[j][NS - j] = w_qbit[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_vld <= '0;
        else        r_vld <= {r_vld[NS-1:0], in_valid};
    end

    always_ff @(posedge clk) begin
        r_sign    <= {r_sign[NS-1:0], w_sign};
        r_finv    <= {r_finv[NS-1:0], w_finv};
        r_fdz     <= {r_fdz[NS-1:0], w_fdz};
        r_spec[0] <= w_spec;
        r_exp[0]  <= w_e;
        r_sigb[0] <= w_sigb;
        r_rem[0]  <= {1'b0, w_siga};
        r_q[0]    <= '0;
        for (int j = 1; j <= NS; j++) begin
            r_spec[j] <= r_spec[j-1];
            r_exp[j]  <= r_exp[j-1];
            r_rem[j]  <= w_rem[j];
            r_q[j]    <= w_q[j];
        end
        for (int j = 1; j < NS; j++) begin
            r_sigb[j] <= r_sigb[j-1];
        end
    end

    // ------------------------------------------ normalise, round and pack
    logic [M+1:0]          w_fq;
    logic [M+1:0]          w_ext0, w_ext;
    logic signed [EW-1:0]  w_e1;
    logic                  w_tiny;
    logic [EW-1:0]         w_shamt;
    logic                  w_stk, w_g, w_st, w_up, w_inex, w_ovf;
    logic [M:0]            w_sum;
    logic [EW-1:0]         w_ef;
    logic [W-1:0]          w_res;
    logic [4:0]            w_flags;

    assign w_fq = r_q[NS];

    always_comb begin
        if (w_fq[M+1]) begin
            w_ext0 = w_fq;
            w_e1   = r_exp[NS];
        end else begin
            w_ext0 = {w_fq[M:0], 1'b0};
            w_e1   = r_exp[NS] - EW'(1);
        end
        w_tiny  = w_e1[EW-1] || (w_e1 == '0);
        w_shamt = '0;
        if (w_tiny) begin
            w_shamt = EW'(1) - w_e1;
            if (w_shamt > EW'(M + 2)) w_shamt = EW'(M + 2);
        end
        w_ext = w_ext0 >> w_shamt;
        // Any bit lost by the denormalising shift shows up when shifting back
        w_stk = (|r_rem[NS]) || ((w_ext << w_shamt) != w_ext0);
        w_g    = w_ext[1];
        w_st   = w_ext[0] || w_stk;
        w_up   = w_g && (w_st || w_ext[2]);
        w_sum  = {1'b0, w_ext[M+1:2]} + (M+1)'(w_up);
        w_inex = w_g || w_st;
        if (w_tiny) w_ef = {{(EW-1){1'b0}}, w_sum[M-1]};
        else        w_ef = w_e1 + EW'(w_sum[M]);
        w_ovf  = !w_tiny && (w_ef >= EW'((1 << EXP_W) - 1));

        w_res   = {r_sign[NS], w_ef[EXP_W-1:0], w_sum[MAN_W-1:0]};
        w_flags = {3'b000, w_tiny && w_inex, w_inex};
        if (w_ovf) begin
            w_res   = {r_sign[NS], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = 5'b00101;
        end
        case (r_spec[NS])
            SP_NAN: begin
                w_res   = QNAN;
                w_flags = {r_finv[NS], 4'b0000};
            end
            SP_INF: begin
                w_res   = {r_sign[NS], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_flags = {1'b0, r_fdz[NS], 3'b000};
            end
            SP_ZERO: begin
                w_res   = {r_sign[NS], {(W-1){1'b0}}};
                w_flags = 5'b00000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            result         <= '0;
            flag_invalid   <= 1'b0;
            flag_div_zero  <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            out_valid <= r_vld[NS];
            if (r_vld[NS]) begin
                result         <= w_res;
                flag_invalid   <= w_flags[4];
                flag_div_zero  <= w_flags[3];
                flag_overflow  <= w_flags[2];
                flag_underflow <= w_flags[1];
                flag_inexact   <= w_flags[0];
            end
        end
    end

endmodule
`default_nettype wire
